// File: rtl/data_mem_sched.sv
// data_mem_sched: zero-fills the data memory after reset or on request, then round-robins
// one core/host access per cycle onto it, registering read data for a uniform 1-cycle latency.
`default_nettype none

module data_mem_sched #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [7:0]    core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_rvalid_o,
  output logic [7:0]    core_rdata_o,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [7:0]    host_wdata_i,
  output logic          host_gnt_o,
  output logic          host_rvalid_o,
  output logic [7:0]    host_rdata_o,
  input  logic          clear_start_i,
  output logic          busy_o,
  output logic [AW-1:0] mem_read_addr_o,
  output logic [AW-1:0] mem_write_addr_o,
  output logic          mem_read_en_o,
  output logic          mem_write_en_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_CLEAR = 2'd1,
    S_IDLE  = 2'd2
  } state_e;

  localparam logic          GNT_CORE = 1'b0;
  localparam logic          GNT_HOST = 1'b1;
  localparam logic [AW:0]   CLR_ONE  = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   clr_cnt_q, clr_cnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic          core_rvalid_q, host_rvalid_q;
  logic [7:0]    core_rdata_q, host_rdata_q;

  logic          core_win, host_win, any_gnt, clearing;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_wdata;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    last_gnt_d = last_gnt_q;
    core_win   = 1'b0;
    host_win   = 1'b0;
    case (state_q)
      S_INIT: state_d = S_CLEAR;
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + CLR_ONE;
        if (&clr_cnt_q[AW-1:0]) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clear_start_i) begin
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end else begin
          // On a tie the port that did not win last time goes first.
          core_win = core_req_i & (~host_req_i | (last_gnt_q == GNT_HOST));
          host_win = host_req_i & ~core_win;
          if (core_win)      last_gnt_d = GNT_CORE;
          else if (host_win) last_gnt_d = GNT_HOST;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign any_gnt   = core_win | host_win;
  assign clearing  = (state_q == S_CLEAR);
  assign sel_we    = core_win ? core_we_i    : host_we_i;
  assign sel_addr  = core_win ? core_addr_i  : host_addr_i;
  assign sel_wdata = core_win ? core_wdata_i : host_wdata_i;

  always_comb begin
    mem_write_en_o   = 1'b0;
    mem_write_addr_o = '0;
    mem_wdata_o      = 8'h00;
    mem_read_en_o    = 1'b0;
    mem_read_addr_o  = '0;
    if (clearing) begin
      mem_write_en_o   = 1'b1;
      mem_write_addr_o = clr_cnt_q[AW-1:0];
    end else if (any_gnt && sel_we) begin
      mem_write_en_o   = 1'b1;
      mem_write_addr_o = sel_addr;
      mem_wdata_o      = sel_wdata;
    end else if (any_gnt) begin
      mem_read_en_o    = 1'b1;
      mem_read_addr_o  = sel_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      clr_cnt_q     <= '0;
      last_gnt_q    <= GNT_HOST;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= 8'h00;
      host_rdata_q  <= 8'h00;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      last_gnt_q    <= last_gnt_d;
      core_rvalid_q <= core_win & ~core_we_i;
      host_rvalid_q <= host_win & ~host_we_i;
      if (core_win && !core_we_i) core_rdata_q <= mem_rdata_i;
      if (host_win && !host_we_i) host_rdata_q <= mem_rdata_i;
    end
  end

  assign core_gnt_o    = core_win;
  assign host_gnt_o    = host_win;
  assign core_rvalid_o = core_rvalid_q;
  assign host_rvalid_o = host_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign host_rdata_o  = host_rdata_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_sched.sv
// tb_data_mem_sched: directed stimulus with a read-data scoreboard for data_mem_sched (AW=8).
`default_nettype none

module tb_data_mem_sched;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req, core_we, host_req, host_we, clear_start;
  logic [AW-1:0] core_addr, host_addr;
  logic [7:0]    core_wdata, host_wdata;
  logic          core_gnt, core_rvalid, host_gnt, host_rvalid, busy;
  logic [7:0]    core_rdata, host_rdata;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic          mem_read_en, mem_write_en;
  logic [7:0]    mem_wdata, mem_rdata;

  logic [7:0]    mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  data_mem_sched #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .core_rdata_o(core_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata),
    .clear_start_i(clear_start), .busy_o(busy),
    .mem_read_addr_o(mem_read_addr), .mem_write_addr_o(mem_write_addr),
    .mem_read_en_o(mem_read_en), .mem_write_en_o(mem_write_en),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Behavioural memory: combinational read, write on the clock edge.
  always @(posedge clk) if (mem_write_en) mem[mem_write_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_read_addr];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int due; } exp_t;
  exp_t core_q[$];
  exp_t host_q[$];
  exp_t mon_c, mon_h;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expected read, on its due cycle.
  always @(negedge clk) begin
    if (core_q.size() > 0 && core_q[0].due < cyc) begin
      mon_c = core_q.pop_front();
      chk("core_rvalid_missing", 32'd0, 32'd1);
    end
    if (core_rvalid) begin
      if (core_q.size() == 0) chk("core_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        mon_c = core_q.pop_front();
        chk("core_rdata", {24'd0, core_rdata}, {24'd0, mon_c.data});
        chk("core_rvalid_cycle", cyc, mon_c.due);
      end
    end
    if (host_q.size() > 0 && host_q[0].due < cyc) begin
      mon_h = host_q.pop_front();
      chk("host_rvalid_missing", 32'd0, 32'd1);
    end
    if (host_rvalid) begin
      if (host_q.size() == 0) chk("host_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        mon_h = host_q.pop_front();
        chk("host_rdata", {24'd0, host_rdata}, {24'd0, mon_h.data});
        chk("host_rvalid_cycle", cyc, mon_h.due);
      end
    end
  end

  task automatic set_core(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic push_core(input logic [7:0] d);
    exp_t e; e.data = d; e.due = cyc + 1; core_q.push_back(e);
  endtask

  task automatic push_host(input logic [7:0] d);
    exp_t e; e.data = d; e.due = cyc + 1; host_q.push_back(e);
  endtask

  // Called just after the edge entering CLEAR cycle 1; returns just after the edge into IDLE.
  task automatic fill_check();
    for (int k = 0; k < (1 << AW); k++) begin
      @(negedge clk);
      chk("fill", {12'd0, core_gnt, host_gnt, busy, mem_write_en, mem_write_addr, mem_wdata},
                  {12'd0, 1'b0, 1'b0, 1'b1, 1'b1, k[7:0], 8'h00});
      @(posedge clk); #1;
    end
  endtask

  task automatic init_check();
    chk("init_state", {29'd0, busy, core_gnt | host_gnt, mem_write_en | mem_read_en},
                      {29'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    rst_n = 1'b0;
    clear_start = 1'b0;
    set_core(1'b1, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset values, with a core request pending throughout reset and the fill.
    repeat (3) @(posedge clk);
    @(negedge clk);
    init_check();
    chk("reset_rvalid", {30'd0, core_rvalid, host_rvalid}, 32'd0);
    chk("reset_rdata", {16'd0, core_rdata, host_rdata}, 32'd0);
    rst_n = 1'b1;
    #1 init_check();
    @(posedge clk); #1;
    fill_check();
    @(negedge clk);
    chk("fill_done_busy", {31'd0, busy}, 32'd0);
    chk("first_idle_core_gnt", {31'd0, core_gnt}, 32'd1);
    push_core(8'h00);

    // Core write 0x3C to 0x05, then read it back.
    @(posedge clk); #1;
    set_core(1'b1, 1'b1, 8'h05, 8'h3C);
    @(negedge clk);
    chk("wr_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("wr_mem_port", {15'd0, mem_write_en, mem_write_addr, mem_wdata, mem_read_en},
                       {15'd0, 1'b1, 8'h05, 8'h3C, 1'b0});
    @(posedge clk); #1;
    set_core(1'b1, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    chk("rd_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("rd_mem_port", {23'd0, mem_read_en, mem_read_addr}, {23'd0, 1'b1, 8'h05});
    push_core(8'h3C);

    // Host write 0xA5 to 0x10; leaves the host as last winner.
    @(posedge clk); #1;
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    chk("host_wr_gnt", {30'd0, core_gnt, host_gnt}, {30'd0, 1'b0, 1'b1});

    // Both read continuously: grants alternate starting with the core.
    @(posedge clk); #1;
    set_core(1'b1, 1'b0, 8'h05, 8'h00);
    set_host(1'b1, 1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("rr_gnt_core_turn", {30'd0, core_gnt, host_gnt}, {30'd0, 1'b1, 1'b0});
        push_core(8'h3C);
      end else begin
        chk("rr_gnt_host_turn", {30'd0, core_gnt, host_gnt}, {30'd0, 1'b0, 1'b1});
        push_host(8'hA5);
      end
      @(posedge clk); #1;
    end

    // Host writes 0xFF to 0x80, then clear_start with a competing core request.
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b1, 1'b1, 8'h80, 8'hFF);
    @(negedge clk);
    chk("host_wr80_gnt", {31'd0, host_gnt}, 32'd1);
    @(posedge clk); #1;
    set_host(1'b0, 1'b0, 8'h00, 8'h00);
    set_core(1'b1, 1'b0, 8'h05, 8'h00);
    clear_start = 1'b1;
    @(negedge clk);
    chk("clear_cycle_no_grant", {28'd0, core_gnt, host_gnt, mem_write_en, mem_read_en}, 32'd0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    fill_check();
    set_host(1'b1, 1'b0, 8'h80, 8'h00);
    @(negedge clk);
    chk("clear_done_busy", {31'd0, busy}, 32'd0);
    chk("host_rd80_gnt", {31'd0, host_gnt}, 32'd1);
    push_host(8'h00);

    // Reset on the 100th CLEAR cycle; the fill must restart at address 0.
    @(posedge clk); #1;
    set_host(1'b0, 1'b0, 8'h00, 8'h00);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (99) @(posedge clk);
    #1 chk("clear100_addr", {24'd0, mem_write_addr}, 32'd99);
    set_core(1'b1, 1'b0, 8'h05, 8'h00);
    rst_n = 1'b0;
    #1 init_check();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    init_check();
    rst_n = 1'b1;
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    #1 init_check();
    @(posedge clk); #1;
    fill_check();

    // Reset right after a read grant: the rvalid must never appear.
    set_core(1'b1, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    chk("pre_reset_rd_gnt", {31'd0, core_gnt}, 32'd1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("dropped_rvalid", {31'd0, core_rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    #1 init_check();
    @(posedge clk); #1;
    fill_check();
    @(negedge clk);
    chk("final_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", core_q.size() + host_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
